alu_mc: RTL

Parametrised multi-cycle successor to the single-cycle MIPS ALU. Keeps the existing op encodings (AND, OR, ADD, SUB, SLL) and adds signed SLT plus iterative unsigned multiply and divide. All operations pass through a valid/ready handshake on both input and output. It sits in the execute stage. The datapath stalls on `in_ready`/`out_valid` while a MULU/DIVU is iterating.

---
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// Execute-stage ALU handshake bundle: operand/op request side and result/response side.
// The master drives requests and out_ready; the slave (the ALU) drives everything else.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, data1, data2, op, out_ready,
    input  in_ready, out_valid, result, hi, zero, busy
  );

  modport slave (
    input  in_valid, data1, data2, op, out_ready,
    output in_ready, out_valid, result, hi, zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle MIPS-style ALU: single-cycle logic/arith/shift/SLT ops plus
// iterative shift-add MULU and restoring DIVU behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_mc_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_MULU = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_zero;
  logic               r_out_valid;
  logic               r_busy;

  logic [WIDTH-1:0]   w_simple;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_fin_lo;
  logic [WIDTH-1:0]   w_fin_hi;
  logic               w_is_iter;

  assign w_is_iter = (bus.op == OP_MULU) || (bus.op == OP_DIVU);

  always_comb begin
    w_simple = '0;
    case (bus.op)
      OP_AND:  w_simple = bus.data1 & bus.data2;
      OP_OR:   w_simple = bus.data1 | bus.data2;
      OP_ADD:  w_simple = bus.data1 + bus.data2;
      OP_SUB:  w_simple = bus.data1 - bus.data2;
      OP_SLL:  w_simple = (bus.data2 >= WIDTH'(WIDTH)) ? '0 : (bus.data1 << bus.data2);
      OP_SLT:  w_simple = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
      default: w_simple = '0;
    endcase
  end

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step; a zero divisor always "fits", which naturally yields
  // an all-ones quotient and the dividend as remainder.
  assign w_div_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_rem_next = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_div_ge};

  assign w_fin_lo = r_div ? w_quo_next : w_acc_next[WIDTH-1:0];
  assign w_fin_hi = r_div ? w_rem_next : w_acc_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_div       <= 1'b0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (w_is_iter) begin
              r_state <= BUSY;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(WIDTH);
              r_div   <= (bus.op == OP_DIVU);
              r_b     <= bus.data2;
              r_acc   <= {{WIDTH{1'b0}}, bus.data1};
              r_quo   <= bus.data1;
              r_rem   <= '0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_simple;
              r_hi        <= '0;
              r_zero      <= (w_simple == '0);
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_div) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end else begin
            r_acc <= w_acc_next;
          end
          // Last iteration retires straight into the output registers.
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_fin_lo;
            r_hi        <= w_fin_hi;
            r_zero      <= (w_fin_lo == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;
  assign bus.hi        = r_hi;
  assign bus.zero      = r_zero;
endmodule
